mont_mul_pipe: RTL and testbench

//  Pipelined, parametrised Montgomery multiplier/reducer for the Dilithium NTT datapath.

---
 rtl/mont_pkg.sv | 16 +
 rtl/mont_red_core.sv | 34 +++
 rtl/mont_mul_pipe.sv | 113 +++++++++++
 tb/tb_mont_mul_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared constants and types for the Dilithium Montgomery arithmetic.
package mont_pkg;

  localparam int unsigned DILI_Q    = 32'd8380417;
  localparam int unsigned DILI_QINV = 32'd58728449;
  // 2^32 mod Q, signed representative
  localparam int          DILI_MONT = -4186625;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_RED = 1'b1
  } mont_mode_e;

  typedef logic signed [31:0] coeff_t;

endpackage

// File: rtl/mont_red_core.sv
// Combinational Montgomery reduction arithmetic, split so each half sits
// between its own pipeline registers (t from p, then u from p and t).
module mont_red_core
  import mont_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned Q    = DILI_Q,
  parameter int unsigned QINV = DILI_QINV
) (
  input  logic [DW-1:0]          p_lo,
  output logic [DW-1:0]          t,
  input  logic signed [2*DW-1:0] p_full,
  input  logic [DW-1:0]          t_full,
  output logic [DW-1:0]          u
);

  localparam int unsigned W2 = 2 * DW;
  localparam logic [DW-1:0]          QINV_W = DW'(QINV);
  localparam logic signed [W2-1:0]   Q_W    = W2'(Q);

  logic signed [W2-1:0] t_ext;

  // t = low DW bits of p * QINV; only the low half of p matters mod 2^DW
  always_comb begin
    t = p_lo * QINV_W;
  end

  // u = (p - sext(t)*Q) >>> DW; low DW bits of the shifted value are exact
  always_comb begin
    t_ext = {{DW{t_full[DW-1]}}, t_full};
    u     = DW'((p_full - t_ext * Q_W) >>> DW);
  end

endmodule

// File: rtl/mont_mul_pipe.sv
// Four-stage Montgomery multiplier/reducer with a global-enable valid/ready
// pipeline and a sideband tag carried alongside each beat.
module mont_mul_pipe
  import mont_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned Q     = DILI_Q,
  parameter int unsigned QINV  = DILI_QINV,
  parameter bit          CANON = 1'b1,
  parameter int unsigned TAG_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              mode_i,
  input  logic [DW-1:0]     a_i,
  input  logic [DW-1:0]     b_i,
  input  logic [2*DW-1:0]   wide_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DW-1:0]     res_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int unsigned W2 = 2 * DW;

  logic                 en;
  logic signed [W2-1:0] a_ext;
  logic signed [W2-1:0] b_ext;
  logic signed [W2-1:0] p_c;
  logic [DW-1:0]        t_c;
  logic [DW-1:0]        u_c;
  logic [DW-1:0]        res_c;

  logic                 s1_v;
  logic                 s2_v;
  logic                 s3_v;
  logic signed [W2-1:0] s1_p;
  logic signed [W2-1:0] s2_p;
  logic [DW-1:0]        s2_t;
  logic [DW-1:0]        s3_u;
  logic [TAG_W-1:0]     s1_tag;
  logic [TAG_W-1:0]     s2_tag;
  logic [TAG_W-1:0]     s3_tag;

  // Whole pipe advances unless a result is waiting on downstream
  always_comb begin
    en      = !valid_o || ready_i;
    ready_o = en;
  end

  // S1 operand: signed double-width product or the raw wide value
  always_comb begin
    a_ext = {{DW{a_i[DW-1]}}, a_i};
    b_ext = {{DW{b_i[DW-1]}}, b_i};
    p_c   = (mont_mode_e'(mode_i) == MODE_RED) ? $signed(wide_i) : a_ext * b_ext;
  end

  mont_red_core #(
    .DW   (DW),
    .Q    (Q),
    .QINV (QINV)
  ) u_core (
    .p_lo   (s1_p[DW-1:0]),
    .t      (t_c),
    .p_full (s2_p),
    .t_full (s2_t),
    .u      (u_c)
  );

  // Optional fold of (-Q,0) into (0,Q); zero stays zero
  always_comb begin
    res_c = (CANON && s3_u[DW-1]) ? s3_u + DW'(Q) : s3_u;
  end

  // Stage registers; result/tag only update when a valid beat lands in S4
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s3_v    <= 1'b0;
      valid_o <= 1'b0;
      s1_p    <= '0;
      s2_p    <= '0;
      s2_t    <= '0;
      s3_u    <= '0;
      s1_tag  <= '0;
      s2_tag  <= '0;
      s3_tag  <= '0;
      res_o   <= '0;
      tag_o   <= '0;
    end else if (en) begin
      s1_v    <= valid_i;
      s1_p    <= p_c;
      s1_tag  <= tag_i;
      s2_v    <= s1_v;
      s2_p    <= s1_p;
      s2_t    <= t_c;
      s2_tag  <= s1_tag;
      s3_v    <= s2_v;
      s3_u    <= u_c;
      s3_tag  <= s2_tag;
      valid_o <= s3_v;
      if (s3_v) begin
        res_o <= res_c;
        tag_o <= s3_tag;
      end
    end
  end

endmodule

// File: tb/tb_mont_mul_pipe.sv
// Bench for mont_mul_pipe: canonical and raw instances side by side,
// vector table plus directed stall/reset sequences, scoreboarded outputs.
module tb_mont_mul_pipe;
  import mont_pkg::*;

  typedef struct {
    bit          mode;
    int          a;
    int          b;
    longint      wide;
    logic [7:0]  tag;
    longint      exp_canon;
    longint      exp_raw;
  } vec_t;

  typedef struct {
    longint      canon;
    longint      raw;
    logic [7:0]  tag;
    int          acc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        mode_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [63:0] wide_i;
  logic [7:0]  tag_i;
  logic        ready_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] res_o;
  logic [7:0]  tag_o;
  logic        ready_raw;
  logic        valid_raw;
  logic [31:0] res_raw;
  logic [7:0]  tag_raw;

  always #5 clk = ~clk;

  mont_mul_pipe #(.CANON(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .mode_i(mode_i), .a_i(a_i), .b_i(b_i), .wide_i(wide_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .tag_o(tag_o)
  );

  mont_mul_pipe #(.CANON(1'b0)) dut_raw (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_raw),
    .mode_i(mode_i), .a_i(a_i), .b_i(b_i), .wide_i(wide_i), .tag_i(tag_i),
    .valid_o(valid_raw), .ready_i(ready_i), .res_o(res_raw), .tag_o(tag_raw)
  );

  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  int   n_pop  = 0;
  bit   chk_lat = 1'b0;
  sb_t  cur;
  sb_t  sb[$];
  vec_t tbl[10];
  vec_t svec[64];

  // Reference montgomery_reduce on a signed 64-bit value
  function automatic longint mont_ref(input longint p);
    int     t;
    longint u;
    t = int'(p) * int'(DILI_QINV);
    u = (p - longint'(t) * longint'(DILI_Q)) >>> 32;
    return longint'(int'(u));
  endfunction

  function automatic longint canon(input longint r);
    return (r < 0) ? r + longint'(DILI_Q) : r;
  endfunction

  function automatic vec_t mk_mul(input int a, input int b, input logic [7:0] tag);
    vec_t v;
    longint r;
    r = mont_ref(longint'(a) * longint'(b));
    v = '{mode: 1'b0, a: a, b: b, wide: 64'd0, tag: tag, exp_canon: canon(r), exp_raw: r};
    return v;
  endfunction

  function automatic vec_t mk_red(input longint w, input logic [7:0] tag,
                                  input longint ec, input longint er);
    vec_t v;
    v = '{mode: 1'b1, a: 0, b: 0, wide: w, tag: tag, exp_canon: ec, exp_raw: er};
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: observe at the falling edge, return just after the rising edge
  task automatic tick(output bit acc);
    sb_t e;
    @(negedge clk);
    cyc++;
    acc = 1'b0;
    if (rst_i) begin
      sb.delete();
    end else begin
      if (valid_o && ready_i) begin
        n_pop++;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got res %0d tag %0d with nothing outstanding", res_o, tag_o);
        end else begin
          e = sb.pop_front();
          chk("res_canon", longint'(coeff_t'(res_o)), e.canon);
          chk("res_raw",   longint'(coeff_t'(res_raw)), e.raw);
          chk("tag",       longint'(tag_o), longint'(e.tag));
          chk("raw_valid", longint'(valid_raw), 1);
          if (chk_lat) chk("latency", longint'(cyc - e.acc), 4);
        end
      end
      if (valid_i && ready_o) begin
        e     = cur;
        e.acc = cyc;
        sb.push_back(e);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    mode_i  = v.mode;
    a_i     = v.a;
    b_i     = v.b;
    wide_i  = v.wide;
    tag_i   = v.tag;
    cur     = '{canon: v.exp_canon, raw: v.exp_raw, tag: v.tag, acc: 0};
  endtask

  task automatic send(input vec_t v);
    bit acc;
    apply(v);
    valid_i = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 64; n++) begin
      tick(acc);
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: got no accept expected accept of tag %0d", v.tag);
    end
  endtask

  task automatic drain();
    bit acc;
    valid_i = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (sb.size() == 0) break;
      tick(acc);
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
    end
    for (int n = 0; n < 6; n++) tick(acc);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_valid_o"}, longint'(valid_o), 0);
    chk({name, "_res_o"},   longint'(res_o), 0);
    chk({name, "_tag_o"},   longint'(tag_o), 0);
    chk({name, "_ready_o"}, longint'(ready_o), 1);
    chk({name, "_raw_rdy"}, longint'(ready_raw), 1);
  endtask

  initial begin
    bit     acc;
    int     idx;
    int     stall;
    int     pop0;
    longint hold_res;
    longint hold_tag;

    tbl[0] = mk_red(longint'(7) << 32, 8'h11, 7, 7);
    tbl[1] = mk_red(-(longint'(5) << 32), 8'h22, 8380412, -5);
    tbl[2] = mk_mul(DILI_MONT, 3, 8'h33);
    tbl[2].exp_canon = 3;
    tbl[3] = mk_red(0, 8'h44, 0, 0);
    tbl[4] = mk_red(-(longint'(1) << 32), 8'h55, 8380416, -1);
    tbl[5] = mk_mul(0, 12345, 8'h66);
    tbl[6] = mk_mul(1, 1, 8'h77);
    tbl[7] = mk_mul(int'(DILI_Q) - 1, 1 - int'(DILI_Q), 8'h88);
    tbl[8] = mk_red(longint'(DILI_Q - 1) << 32, 8'h99, 8380416, 8380416);
    tbl[9] = mk_mul(DILI_MONT, DILI_MONT, 8'haa);
    tbl[9].exp_canon = 4193792;

    for (int i = 0; i < 64; i++) begin
      svec[i] = mk_mul(int'($urandom_range(0, 16760832)) - 8380416,
                       int'($urandom_range(0, 16760832)) - 8380416, 8'(i));
    end

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    mode_i = 1'b0; a_i = '0; b_i = '0; wide_i = '0; tag_i = '0;
    cur = '{canon: 0, raw: 0, tag: 8'h00, acc: 0};
    for (int n = 0; n < 3; n++) tick(acc);
    rst_i = 1'b0;
    check_idle("reset");

    // Vector table: single beats first (latency), then back to back
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i]);
      drain();
    end
    for (int i = 0; i < 10; i++) send(tbl[i]);
    drain();

    // Random MUL stream with pseudo-random backpressure
    chk_lat = 1'b0;
    idx = 0; stall = 0; pop0 = n_pop;
    for (int c = 0; c < 3000 && idx < 64; c++) begin
      if (stall > 0) begin
        ready_i = 1'b0;
        stall--;
      end else if ($urandom_range(0, 3) == 0) begin
        ready_i = 1'b0;
        stall = int'($urandom_range(0, 4));
      end else begin
        ready_i = 1'b1;
      end
      apply(svec[idx]);
      valid_i = ($urandom_range(0, 7) != 0);
      tick(acc);
      if (acc) idx++;
    end
    chk("stream_sent", longint'(idx), 64);
    ready_i = 1'b1;
    drain();
    chk("stream_count", longint'(n_pop - pop0), 64);

    // Fill the pipe against a blocked sink, hold, then release
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(tbl[i]);
    valid_i = 1'b0;
    hold_res = longint'(res_o);
    hold_tag = longint'(tag_o);
    chk("full_tag", hold_tag, longint'(tbl[0].tag));
    for (int k = 0; k < 3; k++) begin
      chk("stall_ready_o", longint'(ready_o), 0);
      chk("stall_valid_o", longint'(valid_o), 1);
      chk("stall_res_o",   longint'(res_o), hold_res);
      chk("stall_tag_o",   longint'(tag_o), hold_tag);
      tick(acc);
    end
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("burst_valid_o", longint'(valid_o), 1);
      tick(acc);
    end
    chk("burst_end_valid_o", longint'(valid_o), 0);
    drain();

    // Reset with three beats in flight, then a beat right after release
    for (int i = 4; i < 7; i++) send(tbl[i]);
    valid_i = 1'b0;
    rst_i = 1'b1;
    tick(acc);
    rst_i = 1'b0;
    check_idle("midreset");
    chk_lat = 1'b1;
    pop0 = n_pop;
    send(tbl[7]);
    drain();
    chk("post_reset_count", longint'(n_pop - pop0), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
